regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side companion to the register file: on a start request, sequentially reads a contiguous range of architectural registers through one read port.
- Streams each value out over a valid/ready interface tagged with its register number.
- Used by the debug/trace unit to snapshot CPU state without stalling the write side.
- Full throughput of one register per cycle once streaming.

Parameters:
- DATA_W, 64, width of each register and of out_data.
- NUM_REGS, 32, number of registers in the file.
- ADDR_W, 5, register index width (log2 NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- start_addr  input  ADDR_W  first register index to read.
- count  input  ADDR_W+1  number of registers to read; 0 is a no-op; values >NUM_REGS clamp to NUM_REGS.
- busy  output  1  high from the cycle after an accepted start until done.
- rd_addr  output  ADDR_W  read-port address to the register file.
- rd_data  input  DATA_W  register file read data, combinational from rd_addr.
- out_valid  output  1  out_data/out_addr/out_last valid.
- out_ready  input  1  consumer accepts the beat when out_valid&&out_ready.
- out_data  output  DATA_W  captured register value.
- out_addr  output  ADDR_W  index of the register in out_data.
- out_last  output  1  marks the final beat of the dump.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, immediate): state IDLE; busy, out_valid, out_last, done = 0; out_data, out_addr, rd_addr, ptr, remaining = 0.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - start with count!=0 → ptr<=start_addr, remaining<=min(count,NUM_REGS), go FETCH.
  - start with count==0 → no state change, no done.
- FETCH (busy=1, rd_addr=ptr):
  - capture rd_data into out_data; out_addr<=ptr; ptr<=ptr+1.
  - out_last<=(remaining==1); go SEND with out_valid=1.
- SEND (busy=1, rd_addr=ptr, i.e. already the next register):
  - out_valid held with stable data until handshake.
  - Handshake with remaining>1: capture rd_data(ptr), out_addr<=ptr, ptr++, remaining--, out_last<=(remaining==2), stay SEND, out_valid stays 1.
  - Handshake with remaining==1: out_valid<=0, go IDLE, done=1 for the next cycle.
- Latency: start accepted at edge N → out_valid at edge N+2 → back-to-back beats while out_ready=1.
- Address arithmetic: ptr wraps modulo NUM_REGS (31+1 → 0).
- Coherence: each register value is sampled at its own capture edge; a write landing before that edge is visible, a later write is not.
- start while busy: ignored, no effect on the current dump.
- Reset mid-dump: dump aborted, no done pulse, outputs to reset values.

Optional Feature:
- Macro REGDUMP_PARITY_EN.
- Defined: adds output out_parity (1 bit) = even parity (XOR-reduce) of out_data, registered with out_data, reset 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package regdump_pkg: DATA_W/ADDR_W/NUM_REGS constants, reg_idx_t (logic [ADDR_W-1:0]), reg_data_t, state enum dump_state_t {IDLE, FETCH, SEND}.
- No sub-module: FSM, pointer/remaining counters and output registers stay in one module (~150–250 lines).

Test Plan:
- Reset, then start_addr=3, count=4, out_ready=1, regfile Xi=i*0x1111 → beats at cycles 2..5 with out_addr 3,4,5,6 and data 0x3333..0x6666; out_last on addr 6; done pulse the following cycle.
- start_addr=30, count=4 → out_addr sequence 30,31,0,1 (wrap); count=40 → exactly 32 beats.
- out_ready low for 3 cycles mid-stream → out_valid/out_data/out_addr stable throughout; no beat lost or duplicated.
- start pulsed while busy with start_addr=10 → ignored; original sequence completes unchanged. count=0 → busy never asserts, no done.
- Assert rst during the 2nd beat → next sample shows out_valid=0, busy=0, no done; a new start succeeds normally.
- REGDUMP_PARITY_EN defined, register value 0x7 → out_parity=1; value 0x3 → out_parity=0.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, types and FSM state encoding for the register-file dump reader.
// Latency: n/a (types only). Backpressure: n/a.
// Build option: REGDUMP_PARITY_EN adds an even-parity bit alongside each dumped value.
package regdump_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  reg_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dump_state_t;

  // Requests longer than the file are trimmed to one full pass over it.
  function automatic reg_cnt_t clamp_count(input reg_cnt_t req);
    if (req > reg_cnt_t'(NUM_REGS)) return reg_cnt_t'(NUM_REGS);
    return req;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's request, register-file read port and output stream.
// Latency: n/a (wires only). Backpressure: out_ready stalls the output stream.
// Ports: start/start_addr/count request; busy/done status; rd_addr/rd_data read port;
//        out_valid/out_ready/out_data/out_addr/out_last stream (+ out_parity under REGDUMP_PARITY_EN).
// master = the dump reader, slave = requester / register file / consumer side.
interface regfile_dump_reader_if;
  import regdump_pkg::*;

  logic      start;
  reg_idx_t  start_addr;
  reg_cnt_t  count;
  logic      busy;
  reg_idx_t  rd_addr;
  reg_data_t rd_data;
  logic      out_valid;
  logic      out_ready;
  reg_data_t out_data;
  reg_idx_t  out_addr;
  logic      out_last;
  logic      done;
`ifdef REGDUMP_PARITY_EN
  logic      out_parity;
`endif

  modport master (
    input  start, start_addr, count, rd_data, out_ready,
    output busy, rd_addr, out_valid, out_data, out_addr, out_last, done
`ifdef REGDUMP_PARITY_EN
    , output out_parity
`endif
  );

  modport slave (
    output start, start_addr, count, rd_data, out_ready,
    input  busy, rd_addr, out_valid, out_data, out_addr, out_last, done
`ifdef REGDUMP_PARITY_EN
    , input out_parity
`endif
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, wrapping range of registers out of a register file, tagged with index.
// Latency: start accepted at edge N -> first out_valid after edge N+1, then one beat per cycle.
// Backpressure: out_ready low holds out_valid/out_data/out_addr/out_last stable; no beat is lost.
// Ports: clk, rst (async active-high); bus (regfile_dump_reader_if.master).
// Build option: REGDUMP_PARITY_EN adds bus.out_parity, even parity of out_data, registered with it.
module regfile_dump_reader
  import regdump_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  regfile_dump_reader_if.master bus
);

  dump_state_t state;
  reg_idx_t    ptr;        // next register to read; rd_addr follows it directly
  reg_cnt_t    remaining;  // beats still owed, including the one currently on the output

  logic beat_taken;
  assign beat_taken = bus.out_valid && bus.out_ready;

  // The read port always points one register ahead of the output stage so the
  // next value is ready to capture on the same edge the current beat is taken.
  assign bus.rd_addr = ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      bus.busy     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_addr <= '0;
      bus.out_last <= 1'b0;
      bus.done     <= 1'b0;
`ifdef REGDUMP_PARITY_EN
      bus.out_parity <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length request is dropped without touching any state.
          if (bus.start && (bus.count != '0)) begin
            ptr       <= bus.start_addr;
            remaining <= clamp_count(bus.count);
            bus.busy  <= 1'b1;
            state     <= FETCH;
          end
        end

        FETCH: begin
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= ptr;
          bus.out_last  <= (remaining == reg_cnt_t'(1));
          bus.out_valid <= 1'b1;
`ifdef REGDUMP_PARITY_EN
          bus.out_parity <= ^bus.rd_data;
`endif
          ptr   <= ptr + 1'b1;  // wraps modulo NUM_REGS through the index width
          state <= SEND;
        end

        SEND: begin
          if (beat_taken) begin
            if (remaining > reg_cnt_t'(1)) begin
              // Refill the output from the already-addressed next register.
              bus.out_data <= bus.rd_data;
              bus.out_addr <= ptr;
              bus.out_last <= (remaining == reg_cnt_t'(2));
`ifdef REGDUMP_PARITY_EN
              bus.out_parity <= ^bus.rd_data;
`endif
              ptr       <= ptr + 1'b1;
              remaining <= remaining - 1'b1;
            end else begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              remaining     <= '0;
              state         <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
